// File: rtl/score_pkg.sv
// Shared geometry, VGA bus layout and conversion-state encoding for the score overlay.
package score_pkg;

    localparam int VGA_BUS_SIZE = 38;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    localparam int CELL_W      = 20;
    localparam int CELL_H      = 36;
    localparam int SEG_T       = 4;
    localparam int MID_ROW     = 16;
    localparam int ONES_OFFSET = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_t;

    function automatic logic [7:0] clamp99(input logic [7:0] s);
        return (s > 8'd99) ? 8'd99 : s;
    endfunction

    function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        lo = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        return {hi, lo};
    endfunction

    // Mask bit order is {g,f,e,d,c,b,a}; col/row are already known to lie inside the cell.
    function automatic logic seg_lit(input logic [11:0] col, input logic [11:0] row,
                                     input logic [6:0] mask);
        logic top_half;
        logic bot_half;
        logic left_col;
        logic right_col;
        top_half  = row < 12'(MID_ROW + SEG_T);
        bot_half  = row >= 12'(MID_ROW);
        left_col  = col < 12'(SEG_T);
        right_col = col >= 12'(CELL_W - SEG_T);
        return (mask[0] && (row < 12'(SEG_T)))
            || (mask[1] && right_col && top_half)
            || (mask[2] && right_col && bot_half)
            || (mask[3] && (row >= 12'(CELL_H - SEG_T)))
            || (mask[4] && left_col && bot_half)
            || (mask[5] && left_col && top_half)
            || (mask[6] && bot_half && top_half);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment mask {g,f,e,d,c,b,a}; non-decimal codes light nothing.
module seg7_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (bcd)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/draw_score.sv
// Overlays two 2-digit player scores on the VGA bus with a fixed 2-cycle pipeline;
// scores are sampled at vblank start and converted to BCD serially.
module draw_score
    import score_pkg::*;
#(
    parameter int          Y0        = 24,
    parameter int          X_P1      = 448,
    parameter int          X_P2      = 548,
    parameter logic [11:0] SCORE_RGB = 12'hFFF
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    input  logic [7:0]              pl1_score,
    input  logic [7:0]              pl2_score,
    output logic [VGA_BUS_SIZE-1:0] vga_out
);

    localparam logic [11:0] LEFT_P1_T = 12'(X_P1);
    localparam logic [11:0] LEFT_P1_O = 12'(X_P1 + ONES_OFFSET);
    localparam logic [11:0] LEFT_P2_T = 12'(X_P2);
    localparam logic [11:0] LEFT_P2_O = 12'(X_P2 + ONES_OFFSET);

    vga_bus_t    bus_in;
    vga_bus_t    bus_s1;
    vga_bus_t    bus_s2;
    logic [3:0]  hit_next;
    logic [3:0]  hit_s1;

    conv_state_t state;
    logic [2:0]  bit_cnt;
    logic        vblnk_prev;
    logic [7:0]  shadow_p1;
    logic [7:0]  shadow_p2;
    logic [7:0]  bcd_p1;
    logic [7:0]  bcd_p2;
    logic [3:0]  p1_tens;
    logic [3:0]  p1_ones;
    logic [3:0]  p2_tens;
    logic [3:0]  p2_ones;

    logic [6:0]  seg_p1_tens;
    logic [6:0]  seg_p1_ones;
    logic [6:0]  seg_p2_tens;
    logic [6:0]  seg_p2_ones;
    logic [6:0]  mask_p1_tens;
    logic [6:0]  mask_p2_tens;

    assign bus_in  = vga_bus_t'(vga_in);
    assign vga_out = bus_s2;

    seg7_decode u_dec_p1_tens (.bcd(p1_tens), .seg(seg_p1_tens));
    seg7_decode u_dec_p1_ones (.bcd(p1_ones), .seg(seg_p1_ones));
    seg7_decode u_dec_p2_tens (.bcd(p2_tens), .seg(seg_p2_tens));
    seg7_decode u_dec_p2_ones (.bcd(p2_ones), .seg(seg_p2_ones));

    // Leading zero of each score is left blank.
    assign mask_p1_tens = (p1_tens == 4'd0) ? 7'd0 : seg_p1_tens;
    assign mask_p2_tens = (p2_tens == 4'd0) ? 7'd0 : seg_p2_tens;

    function automatic logic digit_hit(input logic [10:0] hc, input logic [10:0] vc,
                                       input logic [11:0] left, input logic [6:0] mask);
        logic [11:0] dx;
        logic [11:0] dy;
        dx = {1'b0, hc} - left;
        dy = {1'b0, vc} - 12'(Y0);
        return (dx < 12'(CELL_W)) && (dy < 12'(CELL_H)) && seg_lit(dx, dy, mask);
    endfunction

    always_comb begin
        hit_next    = 4'b0000;
        hit_next[0] = digit_hit(bus_in.hcount, bus_in.vcount, LEFT_P1_T, mask_p1_tens);
        hit_next[1] = digit_hit(bus_in.hcount, bus_in.vcount, LEFT_P1_O, seg_p1_ones);
        hit_next[2] = digit_hit(bus_in.hcount, bus_in.vcount, LEFT_P2_T, mask_p2_tens);
        hit_next[3] = digit_hit(bus_in.hcount, bus_in.vcount, LEFT_P2_O, seg_p2_ones);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bus_s1 <= '0;
            hit_s1 <= 4'b0000;
            bus_s2 <= '0;
        end else begin
            bus_s1 <= bus_in;
            hit_s1 <= hit_next;
            bus_s2 <= bus_s1;
            if ((|hit_s1) && !bus_s1.hblnk && !bus_s1.vblnk) begin
                bus_s2.rgb <= SCORE_RGB;
            end
        end
    end

    // Shift-add-3 runs on both scores together; displayed digits move only in LOAD,
    // which always falls inside vertical blanking.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            vblnk_prev <= 1'b0;
            shadow_p1  <= 8'd0;
            shadow_p2  <= 8'd0;
            bcd_p1     <= 8'd0;
            bcd_p2     <= 8'd0;
            p1_tens    <= 4'd0;
            p1_ones    <= 4'd0;
            p2_tens    <= 4'd0;
            p2_ones    <= 4'd0;
        end else begin
            vblnk_prev <= bus_in.vblnk;
            case (state)
                ST_IDLE: begin
                    if (bus_in.vblnk && !vblnk_prev) begin
                        shadow_p1 <= clamp99(pl1_score);
                        shadow_p2 <= clamp99(pl2_score);
                        bcd_p1    <= 8'd0;
                        bcd_p2    <= 8'd0;
                        bit_cnt   <= 3'd0;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_p1, shadow_p1} <= {bcd_adjust(bcd_p1), shadow_p1} << 1;
                    {bcd_p2, shadow_p2} <= {bcd_adjust(bcd_p2), shadow_p2} << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    p1_tens <= bcd_p1[7:4];
                    p1_ones <= bcd_p1[3:0];
                    p2_tens <= bcd_p2[7:4];
                    p2_ones <= bcd_p2[3:0];
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_score.sv
// Randomized bench for draw_score: a rendering model built from digit/segment tables
// predicts every output word, plus targeted pixel probes with hand-derived colours.
module tb_draw_score;
    import score_pkg::*;

    localparam logic [11:0] BG    = 12'h123;
    localparam logic [11:0] WHITE = 12'hFFF;

    logic                    pclk = 1'b0;
    logic                    rst;
    logic [VGA_BUS_SIZE-1:0] vga_in;
    logic [7:0]              pl1_score;
    logic [7:0]              pl2_score;
    logic [VGA_BUS_SIZE-1:0] vga_out;

    int compared   = 0;
    int mismatched = 0;

    int       disp1, disp2, pend1, pend2, busy;
    bit       prev_vb;
    vga_bus_t exp_d1, exp_d2;
    vga_bus_t got_q[$];
    vga_bus_t exp_q[$];

    string digit_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                               "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    always #5 pclk = ~pclk;

    draw_score dut (
        .pclk     (pclk),
        .rst      (rst),
        .vga_in   (vga_in),
        .pl1_score(pl1_score),
        .pl2_score(pl2_score),
        .vga_out  (vga_out)
    );

    function automatic bit rect_hit(string segs, int col, int row);
        bit hit = 0;
        for (int i = 0; i < segs.len(); i++) begin
            case (segs[i])
                "a": hit |= (row <= 3);
                "b": hit |= (col >= 16 && row <= 19);
                "c": hit |= (col >= 16 && row >= 16);
                "d": hit |= (row >= 32);
                "e": hit |= (col <= 3 && row >= 16);
                "f": hit |= (col <= 3 && row <= 19);
                "g": hit |= (row >= 16 && row <= 19);
                default: ;
            endcase
        end
        return hit;
    endfunction

    function automatic bit model_lit(int x, int y, int s1, int s2);
        int c1 = (s1 > 99) ? 99 : s1;
        int c2 = (s2 > 99) ? 99 : s2;
        int lefts [4] = '{448, 476, 548, 576};
        int vals  [4];
        vals = '{c1 / 10, c1 % 10, c2 / 10, c2 % 10};
        for (int i = 0; i < 4; i++) begin
            if ((i % 2 == 0) && vals[i] == 0) continue;
            if (x >= lefts[i] && x < lefts[i] + 20 && y >= 24 && y < 60) begin
                if (rect_hit(digit_segs[vals[i]], x - lefts[i], y - 24)) return 1;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        disp1 = 0; disp2 = 0; pend1 = 0; pend2 = 0; busy = 0;
        prev_vb = 0; exp_d1 = '0; exp_d2 = '0;
    endtask

    // Drives one pixel and returns what the DUT shows now plus what it should show.
    task automatic step(input vga_bus_t b, output vga_bus_t got, output vga_bus_t exp);
        vga_bus_t e;
        @(negedge pclk);
        vga_in = b;
        e = b;
        if (!b.hblnk && !b.vblnk && model_lit(int'(b.hcount), int'(b.vcount), disp1, disp2))
            e.rgb = WHITE;
        @(posedge pclk);
        #1;
        if (busy > 0) begin
            busy--;
            if (busy == 0) begin disp1 = pend1; disp2 = pend2; end
        end else if (b.vblnk && !prev_vb) begin
            pend1 = int'(pl1_score); pend2 = int'(pl2_score); busy = 9;
        end
        prev_vb = b.vblnk;
        exp_d2 = exp_d1;
        exp_d1 = e;
        got = vga_bus_t'(vga_out);
        exp = exp_d2;
    endtask

    function automatic vga_bus_t rand_bus();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return vga_bus_t'(r[37:0]);
    endfunction

    task automatic drive_frame();
        vga_bus_t b, g, e;
        for (int y = 20; y < 64; y++) begin
            for (int x = 444; x <= 600; x++) begin
                b = rand_bus();
                b.hcount = 11'(x);
                b.vcount = 11'(y);
                b.vblnk  = 1'b0;
                b.hblnk  = ($urandom_range(0, 19) == 0);
                step(b, g, e);
                got_q.push_back(g); exp_q.push_back(e);
            end
        end
        for (int k = 0; k < 16; k++) begin
            b = rand_bus();
            b.hcount = 11'($urandom_range(440, 610));
            b.vcount = 11'($urandom_range(20, 64));
            b.vblnk  = 1'b1;
            step(b, g, e);
            got_q.push_back(g); exp_q.push_back(e);
        end
    endtask

    task automatic probe(input int x, input int y, output logic [11:0] rgb);
        vga_bus_t b, g, e;
        b = '0;
        b.hcount = 11'(x); b.vcount = 11'(y); b.rgb = BG;
        step(b, g, e);
        b = '0;
        step(b, g, e);
        rgb = g.rgb;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pl1_score = 8'd0; pl2_score = 8'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            vga_in = rand_bus();
        end
        #1;
        compared++;
        if (vga_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_out got=%h want=0", vga_out);
        end
        @(negedge pclk);
        vga_in = '0;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_zero_frame();
        logic [11:0] rgb;
        got_q.delete(); exp_q.delete();
        drive_frame();
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("[TB] FAIL zero_frame[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        probe(476, 24, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL zero_p1_ones got=%h want=%h", rgb, WHITE); end
        probe(576, 40, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL zero_p2_ones_left got=%h want=%h", rgb, WHITE); end
        probe(486, 40, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL zero_no_g got=%h want=%h", rgb, BG); end
        probe(448, 24, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL zero_tens_blank got=%h want=%h", rgb, BG); end
        probe(596, 30, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL zero_outside got=%h want=%h", rgb, BG); end
    endtask

    task automatic test_update();
        logic [11:0] rgb;
        got_q.delete(); exp_q.delete();
        fork
            drive_frame();
            begin
                repeat (3000) @(posedge pclk);
                #2;
                pl1_score = 8'd7; pl2_score = 8'd42;
            end
        join
        drive_frame();
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("[TB] FAIL update_frames[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        probe(476, 24, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL seven_top got=%h want=%h", rgb, WHITE); end
        probe(476, 40, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL seven_mid got=%h want=%h", rgb, BG); end
        probe(548, 40, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL four_f got=%h want=%h", rgb, WHITE); end
        probe(586, 58, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL two_d got=%h want=%h", rgb, WHITE); end
        probe(452, 30, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL p1_tens_blank got=%h want=%h", rgb, BG); end
    endtask

    task automatic test_clamp();
        logic [11:0] rgb;
        got_q.delete(); exp_q.delete();
        pl1_score = 8'd200; pl2_score = 8'd10;
        drive_frame();
        drive_frame();
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("[TB] FAIL clamp_frames[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        probe(448, 24, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL ninety_tens_a got=%h want=%h", rgb, WHITE); end
        probe(448, 54, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL ninety_tens_e got=%h want=%h", rgb, BG); end
        probe(564, 30, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL one_col16 got=%h want=%h", rgb, WHITE); end
        probe(563, 30, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL one_col15 got=%h want=%h", rgb, BG); end
        probe(548, 30, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL one_col0 got=%h want=%h", rgb, BG); end
        probe(576, 50, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL ten_ones_e got=%h want=%h", rgb, WHITE); end
    endtask

    task automatic test_back_to_back();
        vga_bus_t    b, g, e;
        logic [11:0] rgb;
        got_q.delete(); exp_q.delete();
        pl1_score = 8'd33; pl2_score = 8'd58;
        for (int k = 0; k < 18; k++) begin
            b = rand_bus();
            b.hcount = 11'($urandom_range(440, 610));
            b.vcount = 11'($urandom_range(20, 64));
            b.vblnk  = (k == 1 || k == 3);
            step(b, g, e);
            got_q.push_back(g); exp_q.push_back(e);
            if (k == 2) begin pl1_score = 8'd91; pl2_score = 8'd12; end
        end
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_words[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        probe(448, 30, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL b2b_p1_tens got=%h want=%h", rgb, BG); end
        probe(576, 30, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL b2b_p2_ones got=%h want=%h", rgb, WHITE); end
    endtask

    task automatic test_reset_conv();
        vga_bus_t    b, g, e;
        logic [11:0] rgb;
        pl1_score = 8'd55; pl2_score = 8'd66;
        for (int k = 0; k < 5; k++) begin
            b = rand_bus();
            b.vblnk = (k >= 1);
            step(b, g, e);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (vga_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL conv_reset_out got=%h want=0", vga_out);
        end
        @(negedge pclk);
        vga_in = '0;
        repeat (2) @(negedge pclk);
        model_reset();
        rst = 1'b1;
        got_q.delete(); exp_q.delete();
        drive_frame();
        drive_frame();
        foreach (got_q[i]) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("[TB] FAIL post_reset[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        probe(448, 24, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL recapture_tens got=%h want=%h", rgb, WHITE); end
    endtask

    task automatic test_reset_digits();
        logic [11:0] rgb;
        rst = 1'b0;
        @(negedge pclk);
        vga_in = '0;
        @(negedge pclk);
        model_reset();
        rst = 1'b1;
        probe(448, 24, rgb);
        compared++;
        if (rgb !== BG) begin mismatched++; $display("[TB] FAIL reset_tens_blank got=%h want=%h", rgb, BG); end
        probe(476, 24, rgb);
        compared++;
        if (rgb !== WHITE) begin mismatched++; $display("[TB] FAIL reset_ones_zero got=%h want=%h", rgb, WHITE); end
    endtask

    initial begin
        vga_in = '0;
        model_reset();
        test_reset();
        test_zero_frame();
        test_update();
        test_clamp();
        test_back_to_back();
        test_reset_conv();
        test_reset_digits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
